viterbi_decoder: RTL and testbench
==================================

# viterbi_decoder

Hard-decision Viterbi decoder for a rate-1/2, constraint-length-3 convolutional code with generators 7 and 5 (octal). It accepts one 2-bit coded symbol per valid cycle and emits one decoded message bit per valid cycle. Survivor management uses register exchange with a fixed decision depth of 32 symbols. It sits downstream of the channel/demodulator hard slicer and feeds the bit-sink or frame logic.

## Interface
- TB_LEN, 32: decision depth in symbols; also the output latency in accepted symbols.
- MW, 6: path-metric width in bits.
- clk  in  1  clock; all state changes on the rising edge.
- RSTn  in  1  reset; asynchronous, active-high despite the name. Asserted (1) clears all state.
- d_in_valid  in  1  a symbol is present on d_in this cycle.
- d_in  in  2  coded symbol; d_in[1] = G0 (111) output, d_in[0] = G1 (101) output.
- d_out_valid  out  1  d_out carries a decoded bit this cycle.
- d_out  out  1  decoded message bit, oldest first.

## Operation
- Encoder model:
  - State s = {s1, s0}, where s1 is the most recent input bit.
  - For input u: c0 = u^s1^s0 and c1 = u^s0.
  - Next state is {u, s1}. Encoder starts in state 0.
- Branch metric: Hamming distance, 0–2, between d_in and the expected {c0, c1}.
- Add-compare-select (ACS), for each next state ns = {u, p}:
  - The two predecessors are {p, 0} and {p, 1}.
  - Candidate = predecessor metric + branch metric; the smaller candidate wins.
  - Tie: predecessor {p, 0} wins.
- Normalization: after ACS, subtract the minimum of the four new metrics from all four, so the minimum metric is always 0. No overflow is possible at MW = 6.
- Survivors: each state holds a TB_LEN+1 = 33-bit register.
  - Update: new_surv[ns] = {surv[winning pred][31:0], u}.
  - Bit 0 is the newest decision; bit 32 is the oldest.
- Best state: the state with minimum normalized metric after the update; ties go to the lowest state index.
- Output: d_out is bit 32 of the best state's new survivor.
  - Symbol counter cnt counts accepted symbols and saturates at TB_LEN+1.
  - d_out_valid = 1 when the accepted symbol makes cnt ≥ 33.
  - The n-th output, counting from 0, is message bit n, decoded using symbol n+32.
- With d_in_valid = 0: metrics, survivors and counter hold; d_out_valid goes to 0 in the following cycle.
- Reset values:
  - Metrics: state 0 = 0; states 1–3 = 8.
  - Survivors all 0; cnt = 0.
  - d_out_valid = 0, d_out = 0.
- Reset mid-stream discards everything; decoding restarts as if from power-up.
- Flushing the last 32 message bits is the producer's job: append 32 more symbols, which may be all zeros. In a continuous stream, no flush is needed.

## Timing
- Symbol capture: on a rising edge with d_in_valid = 1.
- Outputs are registered. d_out and d_out_valid update on the same edge that accepts the symbol, and are stable for the whole following cycle.
- Latency:
  - First d_out_valid appears in the cycle after the 33rd accepted symbol.
  - Each later output follows its triggering symbol by one edge.
- Throughput: one symbol in and one bit out per clock; no backpressure.
- While d_out_valid = 0, d_out holds its last value.
- Asynchronous reset forces outputs to their reset values immediately, independent of clk.

## Test plan
- All-zero frame: 512 message zeros, encoded, plus 32 symbols of 00 → 512 outputs, all 0; first d_out_valid one cycle after the 33rd symbol.
- Known pattern: message 1,0,1,1 followed by zeros, coded as 11,10,00,01,01,11,00,00,… → outputs start 1,0,1,1,0,0,…
- Error correction: random 512-bit message, encoded, with one flipped coded bit every 20 symbols, plus 32 tail symbols of 00 (544 symbols, 1088 bits) → 512 of 512 outputs match the message.
- Valid gaps: the same stream with d_in_valid deasserted for random 1–5 cycle gaps → identical output sequence; d_out_valid low one cycle after each gap cycle.
- Reset mid-stream: assert RSTn = 1 after 100 symbols → d_out_valid = 0 at once. Restart with a new frame → its first output appears after 33 new symbols and is correct.
- Tie handling: symbols 01,10 repeated from reset → decisions are deterministic under the lowest-index rule; the bench compares against a bit-exact reference model.

Source files
------------

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder, rate 1/2, K=3, generators 7/5 (octal).
// One coded symbol in and, after the decision depth has filled, one decoded bit out per valid cycle.
module viterbi_decoder #(
    parameter int unsigned TB_LEN = 32,
    parameter int unsigned MW     = 6
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       d_in_valid,
    input  logic [1:0] d_in,
    output logic       d_out_valid,
    output logic       d_out
);

    localparam int unsigned SW = TB_LEN + 1;
    localparam int unsigned CW = $clog2(SW + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(SW);

    logic [MW-1:0] metric_q [4];
    logic [MW-1:0] metric_d [4];
    logic [SW-1:0] surv_q   [4];
    logic [SW-1:0] surv_d   [4];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          d_out_q, d_out_d;
    logic          d_out_valid_q, d_out_valid_d;

    logic [MW-1:0] cand_a   [4];
    logic [MW-1:0] cand_b   [4];
    logic [MW-1:0] acs      [4];
    logic [MW-1:0] norm     [4];
    logic [SW-1:0] surv_new [4];
    logic [MW-1:0] min_m;
    logic [1:0]    best;

    // Hamming distance between the received symbol and the branch label for (u, s1, s0).
    function automatic logic [1:0] branch_metric(input logic [1:0] sym, input logic u,
                                                 input logic s1, input logic s0);
        logic c0, c1;
        c0 = u ^ s1 ^ s0;
        c1 = u ^ s0;
        return {1'b0, sym[1] ^ c0} + {1'b0, sym[0] ^ c1};
    endfunction

    always_comb begin
        for (int ns = 0; ns < 4; ns++) begin
            logic [1:0] nsb;
            nsb        = 2'(ns);
            cand_a[ns] = metric_q[{nsb[0], 1'b0}]
                         + MW'(branch_metric(d_in, nsb[1], nsb[0], 1'b0));
            cand_b[ns] = metric_q[{nsb[0], 1'b1}]
                         + MW'(branch_metric(d_in, nsb[1], nsb[0], 1'b1));
            // Ties resolve toward the {p,0} predecessor.
            if (cand_b[ns] < cand_a[ns]) begin
                acs[ns]      = cand_b[ns];
                surv_new[ns] = {surv_q[{nsb[0], 1'b1}][SW-2:0], nsb[1]};
            end else begin
                acs[ns]      = cand_a[ns];
                surv_new[ns] = {surv_q[{nsb[0], 1'b0}][SW-2:0], nsb[1]};
            end
        end

        min_m = acs[0];
        best  = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (acs[i] < min_m) begin
                min_m = acs[i];
                best  = 2'(i);
            end
        end

        for (int i = 0; i < 4; i++) begin
            norm[i] = acs[i] - min_m;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            metric_d[i] = metric_q[i];
            surv_d[i]   = surv_q[i];
        end
        cnt_d         = cnt_q;
        d_out_d       = d_out_q;
        d_out_valid_d = 1'b0;

        if (d_in_valid) begin
            for (int i = 0; i < 4; i++) begin
                metric_d[i] = norm[i];
                surv_d[i]   = surv_new[i];
            end
            cnt_d = (cnt_q >= CNT_FULL) ? CNT_FULL : cnt_q + 1'b1;
            if (cnt_d >= CNT_FULL) begin
                d_out_valid_d = 1'b1;
                d_out_d       = surv_new[best][SW-1];
            end
        end
    end

    always_ff @(posedge clk or posedge RSTn) begin
        if (RSTn) begin
            for (int i = 0; i < 4; i++) begin
                metric_q[i] <= (i == 0) ? '0 : MW'(8);
                surv_q[i]   <= '0;
            end
            cnt_q         <= '0;
            d_out_q       <= 1'b0;
            d_out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                metric_q[i] <= metric_d[i];
                surv_q[i]   <= surv_d[i];
            end
            cnt_q         <= cnt_d;
            d_out_q       <= d_out_d;
            d_out_valid_q <= d_out_valid_d;
        end
    end

    assign d_out       = d_out_q;
    assign d_out_valid = d_out_valid_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: expected bits queued at drive time, popped on d_out_valid.
module tb_viterbi_decoder;

    logic       clk;
    logic       RSTn;
    logic       d_in_valid;
    logic [1:0] d_in;
    logic       d_out_valid;
    logic       d_out;

    int tests_run    = 0;
    int tests_failed = 0;
    int out_cnt      = 0;

    bit         exp_q[$];
    bit         msg[$];
    logic [1:0] stream[$];

    // Reference model state.
    int       m_pm[4];
    bit [32:0] m_sv[4];
    int       m_cnt;

    viterbi_decoder #(
        .TB_LEN(32),
        .MW    (6)
    ) dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .d_in_valid (d_in_valid),
        .d_in       (d_in),
        .d_out_valid(d_out_valid),
        .d_out      (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (d_out_valid === 1'b1) begin
            bit e;
            out_cnt++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_underflow: got output d_out=%0b, required no output", d_out);
            end else begin
                e = exp_q.pop_front();
                if (d_out !== e) begin
                    tests_failed++;
                    $display("FAIL sb_bit%0d: got d_out=%0b, required %0b", out_cnt - 1, d_out, e);
                end
            end
        end
    end

    function automatic logic [1:0] encode(input bit u, inout bit [1:0] st);
        logic [1:0] sym;
        sym[1] = u ^ st[1] ^ st[0];
        sym[0] = u ^ st[0];
        st     = {u, st[1]};
        return sym;
    endfunction

    task automatic build_frame(input int n, input bit errs);
        bit [1:0]   st;
        bit         u;
        logic [1:0] sym;
        st = 2'b00;
        msg.delete();
        stream.delete();
        for (int i = 0; i < n + 32; i++) begin
            u = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i < n) msg.push_back(u);
            sym = encode(u, st);
            if (errs && (i % 20 == 19)) sym[$urandom_range(0, 1)] ^= 1'b1;
            stream.push_back(sym);
        end
    endtask

    task automatic send_sym(input logic [1:0] sym, input bit push, input bit e);
        @(negedge clk);
        d_in_valid = 1'b1;
        d_in       = sym;
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        d_in_valid = 1'b0;
        d_in       = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RSTn       = 1'b1;
        d_in_valid = 1'b0;
        d_in       = 2'b00;
        repeat (2) @(negedge clk);
        RSTn = 1'b0;
        exp_q.delete();
        out_cnt = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pm[i] = (i == 0) ? 0 : 8;
            m_sv[i] = '0;
        end
        m_cnt = 0;
    endtask

    // Forward-iterating trellis: each predecessor offers both branches; first (lowest) wins ties.
    task automatic model_step(input logic [1:0] sym, output bit v, output bit o);
        int        npm[4];
        bit [32:0] nsv[4];
        int        mn, bs, s1, s0, c0, c1, bm, ns, cand;
        bit        ub;
        for (int i = 0; i < 4; i++) begin
            npm[i] = 1 << 30;
            nsv[i] = '0;
        end
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                s1   = (s >> 1) & 1;
                s0   = s & 1;
                c0   = u ^ s1 ^ s0;
                c1   = u ^ s0;
                bm   = (int'(sym[1]) ^ c0) + (int'(sym[0]) ^ c1);
                ns   = u * 2 + s1;
                cand = m_pm[s] + bm;
                ub   = (u == 1);
                if (cand < npm[ns]) begin
                    npm[ns] = cand;
                    nsv[ns] = {m_sv[s][31:0], ub};
                end
            end
        end
        mn = npm[0];
        bs = 0;
        for (int i = 1; i < 4; i++) if (npm[i] < mn) begin mn = npm[i]; bs = i; end
        for (int i = 0; i < 4; i++) begin
            m_pm[i] = npm[i] - mn;
            m_sv[i] = nsv[i];
        end
        m_cnt = (m_cnt < 33) ? m_cnt + 1 : 33;
        v     = (m_cnt >= 33);
        o     = nsv[bs][32];
    endtask

    task automatic test_reset();
        RSTn       = 1'b1;
        d_in_valid = 1'b0;
        d_in       = 2'b00;
        repeat (2) @(negedge clk);
        tests_run++;
        if (d_out_valid !== 1'b0 || d_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%0b d_out=%0b, required 0 0",
                     d_out_valid, d_out);
        end
        // Symbols presented while reset is held must be ignored.
        for (int i = 0; i < 40; i++) send_sym(2'b11, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (d_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: got valid=%0b, required 0", d_out_valid);
        end
        d_in_valid = 1'b0;
        RSTn       = 1'b0;
        exp_q.delete();
        out_cnt = 0;
    endtask

    task automatic test_zero_frame();
        int first;
        do_reset();
        first = -1;
        for (int i = 0; i < 544; i++) begin
            send_sym(2'b00, i < 512, 1'b0);
            if (d_out_valid === 1'b1 && first < 0) first = i;
        end
        idle_cycle();
        if (d_out_valid === 1'b1 && first < 0) first = 544;
        idle_cycle();
        tests_run++;
        if (first != 33) begin
            tests_failed++;
            $display("FAIL zero_latency: first valid after %0d accepted symbols, required 33", first);
        end
        tests_run++;
        if (out_cnt != 512 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_count: got %0d outputs (%0d left), required 512 (0 left)",
                     out_cnt, exp_q.size());
        end
    endtask

    task automatic test_known_pattern();
        logic [1:0] syms[6];
        bit         bits[6];
        syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 72; i++) begin
            if (i < 6) send_sym(syms[i], 1'b1, bits[i]);
            else       send_sym(2'b00, i < 40, 1'b0);
        end
        idle_cycle();
        idle_cycle();
        tests_run++;
        if (out_cnt != 40 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL known_count: got %0d outputs (%0d left), required 40 (0 left)",
                     out_cnt, exp_q.size());
        end
    endtask

    task automatic test_error_correction();
        do_reset();
        build_frame(512, 1'b1);
        for (int i = 0; i < stream.size(); i++) begin
            send_sym(stream[i], i < msg.size(), (i < msg.size()) ? msg[i] : 1'b0);
        end
        idle_cycle();
        idle_cycle();
        tests_run++;
        if (out_cnt != 512 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL err_count: got %0d outputs (%0d left), required 512 (0 left)",
                     out_cnt, exp_q.size());
        end
    endtask

    task automatic test_valid_gaps();
        bit prev_idle;
        int gap_checks;
        do_reset();
        prev_idle  = 1'b0;
        gap_checks = 0;
        for (int i = 0; i < stream.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int g;
                g = $urandom_range(1, 5);
                for (int k = 0; k < g; k++) begin
                    idle_cycle();
                    if (prev_idle && gap_checks < 40) begin
                        gap_checks++;
                        tests_run++;
                        if (d_out_valid !== 1'b0) begin
                            tests_failed++;
                            $display("FAIL gap_valid sym%0d: got valid=%0b, required 0",
                                     i, d_out_valid);
                        end
                    end
                    prev_idle = 1'b1;
                end
            end
            send_sym(stream[i], i < msg.size(), (i < msg.size()) ? msg[i] : 1'b0);
            if (prev_idle) begin
                tests_run++;
                if (d_out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL gap_valid_end sym%0d: got valid=%0b, required 0",
                             i, d_out_valid);
                end
            end
            prev_idle = 1'b0;
        end
        idle_cycle();
        idle_cycle();
        tests_run++;
        if (out_cnt != 512 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL gap_count: got %0d outputs (%0d left), required 512 (0 left)",
                     out_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        int first;
        do_reset();
        build_frame(200, 1'b0);
        for (int i = 0; i < 100; i++) send_sym(stream[i], 1'b1, msg[i]);
        @(negedge clk);
        d_in_valid = 1'b0;
        tests_run++;
        if (d_out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_prevalid: got valid=%0b, required 1", d_out_valid);
        end
        #2 RSTn = 1'b1;
        #1;
        tests_run++;
        if (d_out_valid !== 1'b0 || d_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_async: got valid=%0b d_out=%0b, required 0 0", d_out_valid, d_out);
        end
        exp_q.delete();
        out_cnt = 0;
        repeat (2) @(negedge clk);
        RSTn = 1'b0;
        build_frame(60, 1'b0);
        first = -1;
        for (int i = 0; i < stream.size(); i++) begin
            send_sym(stream[i], i < msg.size(), (i < msg.size()) ? msg[i] : 1'b0);
            if (d_out_valid === 1'b1 && first < 0) first = i;
        end
        idle_cycle();
        idle_cycle();
        tests_run++;
        if (first != 33) begin
            tests_failed++;
            $display("FAIL mid_latency: first valid after %0d new symbols, required 33", first);
        end
        tests_run++;
        if (out_cnt != 60 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL mid_count: got %0d outputs (%0d left), required 60 (0 left)",
                     out_cnt, exp_q.size());
        end
    endtask

    task automatic test_ties();
        bit         v, o;
        int         nexp;
        logic [1:0] sym;
        do_reset();
        model_reset();
        nexp = 0;
        for (int i = 0; i < 120; i++) begin
            sym = (i % 2 == 0) ? 2'b01 : 2'b10;
            model_step(sym, v, o);
            if (v) nexp++;
            send_sym(sym, v, o);
        end
        idle_cycle();
        idle_cycle();
        tests_run++;
        if (out_cnt != nexp || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL tie_count: got %0d outputs (%0d left), required %0d (0 left)",
                     out_cnt, exp_q.size(), nexp);
        end
    endtask

    initial begin
        RSTn       = 1'b1;
        d_in_valid = 1'b0;
        d_in       = 2'b00;
        test_reset();
        test_zero_frame();
        test_known_pattern();
        test_error_correction();
        test_valid_gaps();
        test_reset_midstream();
        test_ties();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
